// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : FSM state encoding and BCD digit limits for countdown_timer.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE    = 2'd0;
    localparam state_t c_ST_RUN     = 2'd1;
    localparam state_t c_ST_PAUSE   = 2'd2;
    localparam state_t c_ST_EXPIRED = 2'd3;

    localparam int c_MAX_UNITS    = 9;
    localparam int c_MAX_TENS     = 5;
    localparam int c_MAX_HR_T     = 2;
    localparam int c_MAX_HR_U_20S = 3;

endpackage
`default_nettype wire

// File: rtl/down_digit.sv
`default_nettype none
// ============================================================================
// Module      : down_digit
// Description : One BCD down-counting digit; wraps 0 -> MAX and borrows.
// Revision    : 1.0 - initial release
// ============================================================================
module down_digit #(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  logic             clkmain,
    input  logic             clear,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             borrow_out
);
    import clock_pkg::*;

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clkmain) begin
        if (clear) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= (load_value > c_MAX) ? c_MAX : load_value;
        end else if (en) begin
            r_value <= (r_value == '0) ? c_MAX : r_value - 1'b1;
        end
    end

    assign value      = r_value;
    assign borrow_out = en && (r_value == '0);

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : HH:MM:SS BCD countdown with pause/resume and timed alarm.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int ALARM_TICKS = 10
) (
    input  logic       clkmain,
    input  logic       clear,
    input  logic       tick_1hz,
    input  logic       set_time,
    input  logic       start,
    input  logic       pause,
    input  logic [1:0] ld_hr_t,
    input  logic [3:0] ld_hr_u,
    input  logic [2:0] ld_min_t,
    input  logic [3:0] ld_min_u,
    input  logic [2:0] ld_sec_t,
    input  logic [3:0] ld_sec_u,
    output logic [1:0] hr_t,
    output logic [3:0] hr_u,
    output logic [2:0] min_t,
    output logic [3:0] min_u,
    output logic [2:0] sec_t,
    output logic [3:0] sec_u,
    output logic       running,
    output logic       done,
    output logic       alarm
);
    import clock_pkg::*;

    localparam logic [7:0] c_ALARM_LAST = 8'(ALARM_TICKS - 1);

    state_t     r_state;
    logic       r_done;
    logic       r_alarm;
    logic [7:0] r_alarm_cnt;

    logic       w_load;
    logic       w_dec;
    logic       w_nonzero;
    logic       w_last;
    logic [1:0] w_ld_hr_t;
    logic [3:0] w_ld_hr_u;
    logic       w_b_sec_u, w_b_sec_t, w_b_min_u, w_b_min_t, w_b_hr_u;

    assign w_load    = set_time && (r_state != c_ST_RUN);
    assign w_dec     = (r_state == c_ST_RUN) && tick_1hz && !pause;
    assign w_nonzero = |{hr_t, hr_u, min_t, min_u, sec_t, sec_u};
    assign w_last    = ({hr_t, hr_u, min_t, min_u, sec_t} == '0) && (sec_u == 4'd1);

    // The hour-units limit depends on the already-clamped hour tens.
    assign w_ld_hr_t = (ld_hr_t > 2'(c_MAX_HR_T)) ? 2'(c_MAX_HR_T) : ld_hr_t;
    assign w_ld_hr_u = ((w_ld_hr_t == 2'(c_MAX_HR_T)) && (ld_hr_u > 4'(c_MAX_HR_U_20S)))
                       ? 4'(c_MAX_HR_U_20S) : ld_hr_u;

    down_digit #(.WIDTH(4), .MAX(c_MAX_UNITS)) u_sec_u (
        .clkmain(clkmain), .clear(clear), .en(w_dec), .load(w_load),
        .load_value(ld_sec_u), .value(sec_u), .borrow_out(w_b_sec_u));

    down_digit #(.WIDTH(3), .MAX(c_MAX_TENS)) u_sec_t (
        .clkmain(clkmain), .clear(clear), .en(w_b_sec_u), .load(w_load),
        .load_value(ld_sec_t), .value(sec_t), .borrow_out(w_b_sec_t));

    down_digit #(.WIDTH(4), .MAX(c_MAX_UNITS)) u_min_u (
        .clkmain(clkmain), .clear(clear), .en(w_b_sec_t), .load(w_load),
        .load_value(ld_min_u), .value(min_u), .borrow_out(w_b_min_u));

    down_digit #(.WIDTH(3), .MAX(c_MAX_TENS)) u_min_t (
        .clkmain(clkmain), .clear(clear), .en(w_b_min_u), .load(w_load),
        .load_value(ld_min_t), .value(min_t), .borrow_out(w_b_min_t));

    down_digit #(.WIDTH(4), .MAX(c_MAX_UNITS)) u_hr_u (
        .clkmain(clkmain), .clear(clear), .en(w_b_min_t), .load(w_load),
        .load_value(w_ld_hr_u), .value(hr_u), .borrow_out(w_b_hr_u));

    // Counting stops at 00:00:00, so the top digit can never borrow.
    down_digit #(.WIDTH(2), .MAX(c_MAX_HR_T)) u_hr_t (
        .clkmain(clkmain), .clear(clear), .en(w_b_hr_u), .load(w_load),
        .load_value(w_ld_hr_t), .value(hr_t), .borrow_out());

    always_ff @(posedge clkmain) begin
        if (clear) begin
            r_state     <= c_ST_IDLE;
            r_done      <= 1'b0;
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_PAUSE: begin
                    if (set_time) begin
                        r_state <= c_ST_IDLE;
                    end else if (start && !pause && w_nonzero) begin
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (pause) begin
                        r_state <= c_ST_PAUSE;
                    end else if (tick_1hz && w_last) begin
                        r_state     <= c_ST_EXPIRED;
                        r_done      <= 1'b1;
                        r_alarm     <= 1'b1;
                        r_alarm_cnt <= '0;
                    end
                end
                c_ST_EXPIRED: begin
                    if (set_time) begin
                        r_state     <= c_ST_IDLE;
                        r_alarm     <= 1'b0;
                        r_alarm_cnt <= '0;
                    end else if (tick_1hz && r_alarm) begin
                        if (r_alarm_cnt == c_ALARM_LAST) begin
                            r_alarm     <= 1'b0;
                            r_alarm_cnt <= '0;
                        end else begin
                            r_alarm_cnt <= r_alarm_cnt + 8'd1;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign running = (r_state == c_ST_RUN);
    assign done    = r_done;
    assign alarm   = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer
// Description : Directed self-checking bench for countdown_timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;
    import clock_pkg::*;

    logic       clkmain = 1'b0;
    logic       clear, tick_1hz, set_time, start, pause;
    logic [1:0] ld_hr_t;
    logic [3:0] ld_hr_u, ld_min_u, ld_sec_u;
    logic [2:0] ld_min_t, ld_sec_t;
    logic [1:0] hr_t;
    logic [3:0] hr_u, min_u, sec_u;
    logic [2:0] min_t, sec_t;
    logic       running, done, alarm;

    int n_vec = 0;
    int n_err = 0;

    always #5 clkmain = ~clkmain;

    countdown_timer #(.ALARM_TICKS(10)) dut (
        .clkmain(clkmain), .clear(clear), .tick_1hz(tick_1hz),
        .set_time(set_time), .start(start), .pause(pause),
        .ld_hr_t(ld_hr_t), .ld_hr_u(ld_hr_u), .ld_min_t(ld_min_t),
        .ld_min_u(ld_min_u), .ld_sec_t(ld_sec_t), .ld_sec_u(ld_sec_u),
        .hr_t(hr_t), .hr_u(hr_u), .min_t(min_t), .min_u(min_u),
        .sec_t(sec_t), .sec_u(sec_u),
        .running(running), .done(done), .alarm(alarm));

    logic [19:0] w_count;
    assign w_count = {hr_t, hr_u, min_t, min_u, sec_t, sec_u};

    function automatic logic [19:0] hms(input int ht, hu, mt, mu, st, su);
        return {2'(ht), 4'(hu), 3'(mt), 4'(mu), 3'(st), 4'(su)};
    endfunction

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clkmain);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            tick_1hz = 1'b1;
            cyc();
            tick_1hz = 1'b0;
        end
    endtask

    task automatic ld(input int ht, hu, mt, mu, st, su);
        ld_hr_t  = 2'(ht);
        ld_hr_u  = 4'(hu);
        ld_min_t = 3'(mt);
        ld_min_u = 4'(mu);
        ld_sec_t = 3'(st);
        ld_sec_u = 4'(su);
        set_time = 1'b1;
        cyc();
        set_time = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        clear = 1'b1; tick_1hz = 1'b0; set_time = 1'b0; start = 1'b0; pause = 1'b0;
        ld_hr_t = '0; ld_hr_u = '0; ld_min_t = '0; ld_min_u = '0; ld_sec_t = '0; ld_sec_u = '0;
        cyc(); cyc();
        clear = 1'b0;
        chk("reset_count", w_count, hms(0,0,0,0,0,0));
        chk("reset_flags", {17'd0, running, done, alarm}, 20'd0);

        // 00:01:05 -> five ticks -> 00:01:00 -> one more -> 00:00:59
        ld(0,0,0,1,0,5);
        chk("load_0105", w_count, hms(0,0,0,1,0,5));
        go();
        chk("run_start", {19'd0, running}, 20'd1);
        tick(5);
        chk("tick5", w_count, hms(0,0,0,1,0,0));
        tick(1);
        chk("borrow_min", w_count, hms(0,0,0,0,5,9));

        set_time = 1'b1; ld_sec_u = 4'd3;
        cyc();
        set_time = 1'b0;
        chk("set_in_run", w_count, hms(0,0,0,0,5,9));

        pause = 1'b1; cyc(); pause = 1'b0;
        chk("paused", {19'd0, running}, 20'd0);
        tick(1);
        chk("tick_in_pause", w_count, hms(0,0,0,0,5,9));

        // 01:00:00 -> one tick -> 00:59:59
        ld(0,1,0,0,0,0);
        go();
        tick(1);
        chk("borrow_hr", w_count, hms(0,0,5,9,5,9));
        chk("running_hr", {19'd0, running}, 20'd1);

        start = 1'b1; pause = 1'b1; tick_1hz = 1'b1;
        cyc();
        start = 1'b0; pause = 1'b0; tick_1hz = 1'b0;
        chk("pause_wins", {19'd0, running}, 20'd0);
        chk("pause_no_dec", w_count, hms(0,0,5,9,5,9));
        go();
        chk("resume", {19'd0, running}, 20'd1);
        clear = 1'b1; cyc(); clear = 1'b0;
        chk("clear_count", w_count, hms(0,0,0,0,0,0));
        chk("clear_flags", {17'd0, running, done, alarm}, 20'd0);

        // 20:00:00 -> 19:59:59
        ld(2,0,0,0,0,0);
        go();
        tick(1);
        chk("borrow_hr_t", w_count, hms(1,9,5,9,5,9));
        pause = 1'b1; cyc(); pause = 1'b0;

        // Expire, let the alarm count partly, then reload
        ld(0,0,0,0,0,1);
        go();
        tick(1);
        chk("exp1_alarm", {19'd0, alarm}, 20'd1);
        tick(3);
        ld(0,0,0,0,0,2);
        chk("set_exp_alarm", {19'd0, alarm}, 20'd0);
        chk("set_exp_count", w_count, hms(0,0,0,0,0,2));
        chk("set_exp_state", {18'd0, dut.r_state}, {18'd0, c_ST_IDLE});

        // 00:00:02 -> expiry, done pulse, alarm for 10 ticks
        go();
        tick(1);
        chk("exp_pre", w_count, hms(0,0,0,0,0,1));
        chk("exp_pre_flags", {17'd0, running, done, alarm}, 20'b100);
        tick(1);
        chk("exp_count", w_count, hms(0,0,0,0,0,0));
        chk("exp_flags", {17'd0, running, done, alarm}, 20'b011);
        cyc();
        chk("done_1cyc", {17'd0, running, done, alarm}, 20'b001);
        tick(9);
        chk("alarm_9", {19'd0, alarm}, 20'd1);
        tick(1);
        chk("alarm_10", {19'd0, alarm}, 20'd0);
        chk("still_exp", {18'd0, dut.r_state}, {18'd0, c_ST_EXPIRED});
        go();
        chk("start_in_exp", {19'd0, running}, 20'd0);

        // Clamping and start with zero count
        ld(3,7,7,0,6,12);
        chk("clamp_23", w_count, hms(2,3,5,0,5,9));
        ld(1,15,0,0,0,0);
        chk("clamp_19", w_count, hms(1,9,0,0,0,0));
        ld(0,0,0,0,0,0);
        go();
        chk("start_zero", {19'd0, running}, 20'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter ALARM_TICKS, default 10: the number of tick_1hz pulses that alarm stays high after expiry (range 1-255).
REQ-002 The block SHALL have port clkmain, input, 1 bit: the single system clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port clear, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port tick_1hz, input, 1 bit: one-clkmain-cycle enable pulse, once per second.
REQ-005 The block SHALL have port set_time, input, 1 bit: load strobe; captures the ld_* digits.
REQ-006 The block SHALL have port start, input, 1 bit: begin or resume the countdown.
REQ-007 The block SHALL have port pause, input, 1 bit: suspend the countdown.
REQ-008 The block SHALL have ports ld_hr_t[1:0], ld_hr_u[3:0], ld_min_t[2:0], ld_min_u[3:0], ld_sec_t[2:0], ld_sec_u[3:0], all inputs: BCD load digits.
REQ-009 The block SHALL have outputs hr_t[1:0], hr_u[3:0], min_t[2:0], min_u[3:0], sec_t[2:0], sec_u[3:0]: the current BCD count.
REQ-010 The block SHALL have outputs running (1 bit, high in RUN), done (1-cycle expiry pulse) and alarm (1 bit, level).

Function
REQ-011 The block SHALL implement FSM states IDLE, RUN, PAUSE and EXPIRED.
REQ-012 set_time in IDLE, PAUSE or EXPIRED SHALL load the digits on the next edge and go to IDLE; in RUN, set_time SHALL be ignored.
REQ-013 On load, each digit SHALL be clamped to its legal maximum: sec_u/min_u 9, sec_t/min_t 5, hr_t 2, hr_u 9 (3 when the clamped hr_t is 2).
REQ-014 start in IDLE or PAUSE with a nonzero count SHALL go to RUN on the next edge; start with count 00:00:00, or start in EXPIRED, SHALL be ignored.
REQ-015 pause in RUN SHALL go to PAUSE with the count held; when start and pause are both high, pause SHALL win.
REQ-016 In RUN, each tick_1hz SHALL decrement the count by one second in the same edge (latency 1 cycle); tick_1hz outside RUN SHALL be ignored.
REQ-017 Borrow chain: sec_u 0->9 borrows from sec_t; sec_t 0->5 borrows from min_u; min_u 0->9 borrows from min_t; min_t 0->5 borrows from hr_u; hr_u 0->9 borrows from hr_t.
REQ-018 The edge that writes 00:00:00 SHALL also enter EXPIRED, set alarm=1 and pulse done for exactly that one following cycle.
REQ-019 In EXPIRED, alarm SHALL clear after ALARM_TICKS further tick_1hz pulses; the state SHALL remain EXPIRED until set_time or clear.
REQ-020 set_time in EXPIRED SHALL clear alarm and its tick count in the same edge.
REQ-021 A tick_1hz coincident with pause in RUN SHALL NOT decrement.

Reset
REQ-022 clear SHALL force state IDLE, all digits 0, running 0, done 0, alarm 0 and alarm count 0 on the next edge, overriding every other input, including mid-RUN.

Structure
REQ-023 The shared package clock_pkg SHALL hold the state enum and the digit maximum constants (9, 5, 2, 3).
REQ-024 Each digit SHALL be an instance of sub-module down_digit (parameter MAX; inputs en and load; outputs value and borrow_out asserted when en and value==0).

Verification
REQ-025 Load 00:01:05, start, apply 5 ticks -> 00:01:00; 1 more tick -> 00:00:59.
REQ-026 Load 01:00:00, start, 1 tick -> 00:59:59 with running=1.
REQ-027 Load 00:00:02, start, 2 ticks -> 00:00:00, done high for exactly 1 cycle, alarm high; with ALARM_TICKS=10, 10 more ticks -> alarm=0 and state still EXPIRED.
REQ-028 Load with hr_t=3, hr_u=7, sec_u=12 -> reads 23:xx:x9; start with 00:00:00 loaded -> running stays 0.
REQ-029 In RUN, assert start, pause and tick_1hz together -> PAUSE with count unchanged; clear asserted mid-RUN -> all outputs 0 on the next edge.
